// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Iterative binary-to-BCD converter (shift-add-3, one bit per
//                clock) with start/done handshake and saturation to all-nines
//                when the input exceeds the displayable range.
//                Optional macro BIN2BCD_ASCII_EN adds an ASCII output with
//                leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
  parameter int BIN_WIDTH = 10,
  parameter int DIGITS    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [BIN_WIDTH-1:0]  bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  ovf_o
`ifdef BIN2BCD_ASCII_EN
  ,
  output logic [8*DIGITS-1:0]   ascii_o
`endif
);

  localparam int MAX_VAL  = 10**DIGITS - 1;
  localparam int c_ITER_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

  localparam logic [c_ITER_W-1:0] c_ITER_LAST = c_ITER_W'(BIN_WIDTH - 1);
  localparam logic [c_ITER_W-1:0] c_ITER_ONE  = c_ITER_W'(1);
  localparam logic [4*DIGITS-1:0] c_ALL_NINES = {DIGITS{4'h9}};

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]           r_state;
  logic [BIN_WIDTH-1:0] r_shift;
  logic [4*DIGITS-1:0]  r_scratch;
  logic [c_ITER_W-1:0]  r_iter;
  logic                 r_ovf_pend;
  logic                 r_done;
  logic [4*DIGITS-1:0]  r_bcd;
  logic                 r_ovf;

  logic [4*DIGITS-1:0]  w_corr;
  logic [4*DIGITS-1:0]  w_scratch_next;
  logic [BIN_WIDTH-1:0] w_shift_next;
  logic [4*DIGITS-1:0]  w_bcd_final;

  // Add-3 correction on every scratch nibble that would exceed 9 after doubling
  for (genvar g = 0; g < DIGITS; g++) begin : g_nib
    assign w_corr[4*g +: 4] = (r_scratch[4*g +: 4] >= 4'd5) ?
                              (r_scratch[4*g +: 4] + 4'd3) : r_scratch[4*g +: 4];
  end

  assign w_scratch_next = {w_corr[4*DIGITS-2:0], r_shift[BIN_WIDTH-1]};
  assign w_shift_next   = {r_shift[BIN_WIDTH-2:0], 1'b0};
  // Out-of-range inputs display as all nines so no nibble can exceed 9
  assign w_bcd_final    = r_ovf_pend ? c_ALL_NINES : w_scratch_next;

`ifdef BIN2BCD_ASCII_EN
  logic [8*DIGITS-1:0] r_ascii;
  logic [8*DIGITS-1:0] w_ascii_next;
  logic                w_lead;
  logic [3:0]          w_nib;

  // Digit-to-ASCII with leading zeros blanked; the LSD always prints
  always_comb begin
    w_ascii_next = '0;
    w_lead       = 1'b1;
    w_nib        = 4'd0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      w_nib = w_bcd_final[4*d +: 4];
      if (w_lead && (w_nib == 4'd0) && (d != 0)) begin
        w_ascii_next[8*d +: 8] = 8'h20;
      end else begin
        w_lead                 = 1'b0;
        w_ascii_next[8*d +: 8] = {4'h3, w_nib};
      end
    end
  end

  // ASCII result register, updated alongside the BCD result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < DIGITS; d++) begin
        r_ascii[8*d +: 8] <= (d == 0) ? 8'h30 : 8'h20;
      end
    end else if ((r_state == S_SHIFT) && (r_iter == c_ITER_LAST)) begin
      r_ascii <= w_ascii_next;
    end
  end

  assign ascii_o = r_ascii;
`endif

  // Conversion FSM: accept in IDLE, shift BIN_WIDTH times, then publish result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_iter     <= '0;
      r_ovf_pend <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_shift    <= bin_i;
            r_scratch  <= '0;
            r_iter     <= '0;
            r_ovf_pend <= (32'(bin_i) > MAX_VAL);
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_shift   <= w_shift_next;
          r_scratch <= w_scratch_next;
          r_iter    <= r_iter + c_ITER_ONE;
          if (r_iter == c_ITER_LAST) begin
            r_bcd   <= w_bcd_final;
            r_ovf   <= r_ovf_pend;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o = (r_state == S_SHIFT);
  assign done_o = r_done;
  assign bcd_o  = r_bcd;
  assign ovf_o  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin2bcd_seq
//  Description : Scoreboard bench for bin2bcd_seq. The driver pushes the
//                expected result (with its completion cycle) when it issues a
//                start; a monitor checks every cycle against the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

  localparam int BIN_WIDTH = 10;
  localparam int DIGITS    = 3;
  localparam int MAX_VAL   = 999;
  localparam logic [23:0] c_ASCII_RST = 24'h202030;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [9:0]  bin_i;
  logic        busy_o;
  logic        done_o;
  logic [11:0] bcd_o;
  logic        ovf_o;
  logic [23:0] ascii_o;

  bin2bcd_seq #(.BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .bin_i   (bin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .bcd_o   (bcd_o),
    .ovf_o   (ovf_o)
`ifdef BIN2BCD_ASCII_EN
    ,
    .ascii_o (ascii_o)
`endif
  );

`ifndef BIN2BCD_ASCII_EN
  assign ascii_o = c_ASCII_RST;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          accept;
    int          due;
    logic [11:0] bcd;
    logic        ovf;
    logic [23:0] ascii;
  } exp_t;

  exp_t        q[$];
  int          cyc;
  int          n_vec;
  int          n_err;
  logic [11:0] last_bcd;
  logic        last_ovf;
  logic [23:0] last_ascii;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decimal digits by division, saturation, ASCII with blanking
  function automatic exp_t model(int v);
    exp_t e;
    int s, d2, d1, d0;
    s  = (v > MAX_VAL) ? MAX_VAL : v;
    d2 = s / 100;
    d1 = (s / 10) % 10;
    d0 = s % 10;
    e.accept = 0;
    e.due    = 0;
    e.bcd    = 12'((d2 << 8) | (d1 << 4) | d0);
    e.ovf    = (v > MAX_VAL);
    e.ascii  = {8'((d2 == 0) ? 32'h20 : 32'h30 + d2),
                8'((d2 == 0 && d1 == 0) ? 32'h20 : 32'h30 + d1),
                8'(32'h30 + d0)};
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: reset state, busy window, done timing/values and stability
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_bcd", 32'(bcd_o), 32'd0);
      check("rst_ovf", 32'(ovf_o), 32'd0);
`ifdef BIN2BCD_ASCII_EN
      check("rst_ascii", 32'(ascii_o), 32'(c_ASCII_RST));
`endif
      last_bcd   = '0;
      last_ovf   = 1'b0;
      last_ascii = c_ASCII_RST;
    end else begin
      check("busy", 32'(busy_o),
            32'((q.size() > 0) && (q[0].accept <= cyc) && (cyc < q[0].due)));
      if (done_o) begin
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done: got done=1 required done=0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.due));
          check("bcd", 32'(bcd_o), 32'(e.bcd));
          check("ovf", 32'(ovf_o), 32'(e.ovf));
`ifdef BIN2BCD_ASCII_EN
          check("ascii", 32'(ascii_o), 32'(e.ascii));
`endif
          last_bcd   = e.bcd;
          last_ovf   = e.ovf;
          last_ascii = e.ascii;
        end
      end else begin
        if ((q.size() > 0) && (cyc >= q[0].due)) begin
          n_err++;
          $display("FAIL missing_done: got done=0 required done=1 (cycle %0d)", cyc);
          void'(q.pop_front());
        end
        check("bcd_stable", 32'(bcd_o), 32'(last_bcd));
        check("ovf_stable", 32'(ovf_o), 32'(last_ovf));
`ifdef BIN2BCD_ASCII_EN
        check("ascii_stable", 32'(ascii_o), 32'(last_ascii));
`endif
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(int v);
    exp_t e;
    e        = model(v);
    e.accept = cyc + 1;
    e.due    = cyc + 11;
    q.push_back(e);
    n_vec++;
  endtask

  // One conversion: start for one cycle, then idle for gap cycles after done
  task automatic convert(int v, int gap);
    start_i = 1'b1;
    bin_i   = 10'(v);
    push_exp(v);
    step();
    start_i = 1'b0;
    for (int i = 0; i < 10 + gap; i++) begin
      bin_i = 10'($urandom);
      step();
    end
  endtask

  initial begin
    int v;
    int vals[3];
    cyc        = 0;
    n_vec      = 0;
    n_err      = 0;
    last_bcd   = '0;
    last_ovf   = 1'b0;
    last_ascii = c_ASCII_RST;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    bin_i      = '0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Directed values, including back-to-back start in the done cycle (gap 0)
    convert(0, 1);
    convert(999, 1);
    convert(205, 2);
    convert(1023, 0);
    convert(7, 3);
    convert(40, 1);
    convert(1000, 0);
    convert(205, 1);

    // Start during busy is ignored
    start_i = 1'b1;
    bin_i   = 10'd123;
    push_exp(123);
    step();
    start_i = 1'b0;
    repeat (3) step();
    start_i = 1'b1;
    bin_i   = 10'd456;
    step();
    start_i = 1'b0;
    repeat (8) step();

    // Reset in the middle of a conversion aborts it
    start_i = 1'b1;
    bin_i   = 10'd321;
    push_exp(321);
    step();
    start_i = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    convert(321, 1);

    // start_i held high: one conversion every BIN_WIDTH+1 clocks
    vals[0] = 58; vals[1] = 1010; vals[2] = 600;
    start_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bin_i = 10'(vals[k]);
      push_exp(vals[k]);
      step();
      if (k == 2) start_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
        bin_i = 10'($urandom);
        step();
      end
    end
    repeat (2) step();

    // Randomized values with random idle gaps
    for (int n = 0; n < 40; n++) begin
      v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1000, 1023))
                                       : int'($urandom_range(0, 1023));
      convert(v, int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 50 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d pending required 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
